ampm_time_base: RTL
===================

# ampm_time_base

Time-of-day generator that keeps a 24-hour hours/minutes/seconds count from the system clock and produces the `morning_signal` / `after_signal` pair consumed by the A/P display block. It sits upstream of the FND character driver and is the sole source of the AM/PM indication. Both indications stay low until a valid time has been loaded, so the display shows blank. The block also exposes the current time and a once-per-second strobe for other display and alarm logic.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per second. Must be ≥ 2. Benches use 4.
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `run`, input, 1: 1 = time advances; 0 = prescaler and time frozen.
- `set_load`, input, 1: single-cycle load strobe for `set_hour` / `set_min`.
- `set_hour`, input, 5: hour to load, legal range 0..23.
- `set_min`, input, 6: minute to load, legal range 0..59.
- `hour`, output, 5: current hour, 0..23.
- `min`, output, 6: current minute, 0..59.
- `sec`, output, 6: current second, 0..59.
- `time_valid`, output, 1: a legal load has occurred since reset.
- `morning_signal`, output, 1: `time_valid` and `hour` < 12.
- `after_signal`, output, 1: `time_valid` and `hour` ≥ 12.
- `sec_tick`, output, 1: one-cycle pulse on each second advance.
- `set_err`, output, 1: one-cycle pulse when a `set_load` is rejected.

## Operation
- **Reset (async assert, sync release):**
  - `hour`, `min`, `sec` = 0; prescaler = 0.
  - `time_valid` = 0, `morning_signal` = 0, `after_signal` = 0.
  - `sec_tick` = 0, `set_err` = 0.
  - Reset asserted mid-count discards all state immediately.
- **States:**
  - UNSET: entered from reset. Counting is inhibited regardless of `run`. Both AM/PM signals are 0.
  - RUN: entered on the first accepted load. Never returns to UNSET except by reset.
- **Load:**
  - A load is accepted when `set_load`=1, `set_hour` ≤ 23 and `set_min` ≤ 59.
  - On acceptance, at the next edge: `hour`/`min` ← inputs, `sec` ← 0, prescaler ← 0, `time_valid` ← 1.
  - A load is accepted in either state and regardless of `run`.
  - An illegal load leaves all time state unchanged and pulses `set_err`=1 for the cycle after the edge.
- **Prescaler:**
  - Counts 0..`TICKS_PER_SEC`-1 while in RUN and `run`=1.
  - At terminal count it wraps to 0 and the time advances by 1 s on that same edge.
- **Advance:**
  - `sec` wraps 59→0 with carry into `min`.
  - `min` wraps 59→0 with carry into `hour`.
  - `hour` wraps 23→0.
- **AM/PM signals:**
  - Registered; updated on the same edge as `hour`/`time_valid`, so they always match the current register values.
  - Never both 1.
  - Both 0 only while `time_valid`=0.
- **Simultaneous load and terminal count:** the accepted load wins. The tick is discarded and `sec_tick` stays 0.
- **Simultaneous illegal load and terminal count:** the tick proceeds normally and `set_err` pulses.
- **Prescaler width:** clog2(`TICKS_PER_SEC`). No other arithmetic exceeds its field width.

## Timing
- **Load latency:** the edge that samples an accepted `set_load` updates `hour`/`min`/`sec`/`time_valid`/AM-PM signals. The new values are visible 1 cycle after the strobe.
- **First advance:** `sec` first increments on the `TICKS_PER_SEC`-th edge after the load edge.
- **`sec_tick`:** asserted in the cycle following each advance edge, coincident with the new `sec` value. Width exactly 1 cycle.
- **Second period:** successive advances are exactly `TICKS_PER_SEC` cycles apart while `run`=1.
- **`run` deasserted:** prescaler holds its count. Deasserting `run` for N cycles delays the next advance by exactly N cycles.
- **AM/PM transitions:**
  - 11:59:59→12:00:00: `morning_signal` 1→0 and `after_signal` 0→1 on the same edge.
  - 23:59:59→00:00:00: the reverse, on the same edge.
- **`set_err`:** asserted 1 cycle after the rejected strobe, for 1 cycle.

## Test plan
- **Reset and UNSET:** reset, then `run`=1 for 20 cycles with no load → `hour`/`min`/`sec` = 0, `time_valid` = 0, both AM/PM signals 0, `sec_tick` never asserted.
- **Load and first second:** load 09:30 (`TICKS_PER_SEC`=4) → next cycle `morning_signal`=1, `after_signal`=0. 4 edges after the load edge `sec`=1 with `sec_tick`=1 for one cycle.
- **Noon boundary:** load 11:59, run 60 s → at 12:00:00 `morning_signal`=0 and `after_signal`=1 on the same edge. Both signals are never high together.
- **Midnight boundary:** load 23:59, run 60 s → time 00:00:00, `morning_signal`=1, `after_signal`=0.
- **Illegal load:** while at 10:15:07, `set_load` with hour 24 → `set_err` one-cycle pulse, time keeps counting from 10:15:07. `set_load` with min 60 → same behaviour.
- **Pause and collision:** drop `run` for 3 cycles mid-second → next advance delayed exactly 3 cycles. Legal `set_load` on a terminal-count cycle → loaded value with `sec`=0, no `sec_tick`. Assert `rst_n`=0 mid-count → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ampm_time_base.sv
// ampm_time_base: 24-hour time-of-day counter with a settable time, a 1 s strobe
// and the registered AM/PM indication pair for the A/P display.
module ampm_time_base #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_load,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       time_valid,
  output logic       morning_signal,
  output logic       after_signal,
  output logic       sec_tick,
  output logic       set_err
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {
    ST_UNSET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_d;
  logic [5:0]    min_d;
  logic [5:0]    sec_d;
  logic          valid_d;
  logic          morning_d;
  logic          after_d;
  logic          tick_d;
  logic          err_d;

  logic          load_ok_c;
  logic          load_bad_c;
  logic          counting_c;

  assign load_ok_c  = set_load && (set_hour <= 5'd23) && (set_min <= 6'd59);
  assign load_bad_c = set_load && !load_ok_c;
  assign counting_c = (state_q == ST_RUN) && run;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_UNSET;
      presc_q        <= '0;
      hour           <= '0;
      min            <= '0;
      sec            <= '0;
      time_valid     <= 1'b0;
      morning_signal <= 1'b0;
      after_signal   <= 1'b0;
      sec_tick       <= 1'b0;
      set_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      hour           <= hour_d;
      min            <= min_d;
      sec            <= sec_d;
      time_valid     <= valid_d;
      morning_signal <= morning_d;
      after_signal   <= after_d;
      sec_tick       <= tick_d;
      set_err        <= err_d;
    end
  end

  // Next state: an accepted load wins over a coincident terminal count.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hour_d  = hour;
    min_d   = min;
    sec_d   = sec;
    valid_d = time_valid;
    tick_d  = 1'b0;
    err_d   = load_bad_c;

    if (load_ok_c) begin
      state_d = ST_RUN;
      presc_d = '0;
      hour_d  = set_hour;
      min_d   = set_min;
      sec_d   = 6'd0;
      valid_d = 1'b1;
    end else if (counting_c) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec == 6'd59) begin
          sec_d = 6'd0;
          if (min == 6'd59) begin
            min_d  = 6'd0;
            hour_d = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end else begin
            min_d = min + 6'd1;
          end
        end else begin
          sec_d = sec + 6'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    morning_d = valid_d && (hour_d <  5'd12);
    after_d   = valid_d && (hour_d >= 5'd12);
  end

endmodule
